// File: rtl/mcp4822_ma.sv
// MCP4822 dual-DAC SPI master: per sample tick sends ch A then ch B frames, then pulses LDAC_N.
// Latency: frames start the cycle after a tick; outputs update 68*HALF+LDAC_LEN clocks later.
// Backpressure: one-entry holding register, ready_o low while full; empty at tick repeats last sample.
module mcp4822_ma #(
    parameter int CLOCK_FREQ  = 30000000,
    parameter int SCLK_FREQ   = 1000000,
    parameter int SAMPLE_RATE = 20000,
    parameter int GAIN_2X     = 0,
    parameter int LDAC_LEN    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        spi_clk_o,
    output logic        spi_ssn_o,
    output logic        spi_mosi_o,
    output logic        spi_ldac_n_o,
    output logic        busy_o,
    output logic        underrun_o
);

    // Clocks per SCK half period and per sample period.
    localparam int HALF        = CLOCK_FREQ / (2 * SCLK_FREQ);
    localparam int TICK_PERIOD = CLOCK_FREQ / SAMPLE_RATE;

    // Counter widths: the tick counter spans a full sample period, the phase
    // timer only ever holds HALF-1 or LDAC_LEN-1.
    localparam int CW   = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int TMAX = (HALF > LDAC_LEN) ? HALF : LDAC_LEN;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] LDAC_LAST = TW'(LDAC_LEN - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);

    // GA bit of the command word: 1 selects 1x gain, 0 selects 2x gain.
    localparam logic GA_BIT = (GAIN_2X == 0);

    // Reject parameter sets where the sequence could overrun the next tick.
    if (HALF < 1) begin : g_chk_half
        $error("mcp4822_ma: SCLK_FREQ too high for CLOCK_FREQ (HALF < 1)");
    end
    if (LDAC_LEN < 1) begin : g_chk_ldac
        $error("mcp4822_ma: LDAC_LEN must be at least 1");
    end
    if (68 * HALF + LDAC_LEN >= TICK_PERIOD) begin : g_chk_tick
        $error("mcp4822_ma: transfer sequence does not fit in one sample period");
    end

    typedef enum logic [2:0] {
        IDLE,
        SSN_SETUP,
        SHIFT,
        SSN_HOLD,
        GAP,
        LDAC
    } state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic            full;
    logic [23:0]     hold;
    logic [11:0]     last_a;
    logic [11:0]     last_b;
    logic [TW-1:0]   tmr;
    logic [3:0]      bit_cnt;
    logic [15:0]     shreg;
    logic            chan_b;
    logic [11:0]     cur_a;
    logic [15:0]     word_a;
    logic [15:0]     word_b;
    logic            take_sample;

    // Build a DAC command word: channel select, don't-care, gain, SHDN_N=1, data.
    function automatic logic [15:0] cmd_word(input logic ch, input logic [11:0] d);
        return {ch, 1'b0, GA_BIT, 1'b1, d};
    endfunction

    assign ready_o = ~full;
    assign tick    = (tick_cnt == TICK_LAST);

    // A tick in IDLE with a full register consumes the held sample.
    assign take_sample = tick && (state == IDLE) && full;

    // Frame A is loaded on the tick edge, before last_a is updated, so pick the
    // held sample directly when one is being consumed. Frame B starts much
    // later, by which time last_b already holds the right value.
    assign cur_a  = full ? hold[11:0] : last_a;
    assign word_a = cmd_word(1'b0, cur_a);
    assign word_b = cmd_word(1'b1, last_b);

    // Free-running sample-period counter; tick is its terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
        end
    end

    // Holding register and last-sample register. A handshake can only occur
    // when empty and a consume only when full, so the two never collide; a
    // handshake on an empty tick is kept for the following tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full   <= 1'b0;
            hold   <= '0;
            last_a <= 12'h800;
            last_b <= 12'h800;
        end else if (take_sample) begin
            full   <= 1'b0;
            last_a <= hold[11:0];
            last_b <= hold[23:12];
        end else if (valid_i && !full) begin
            full <= 1'b1;
            hold <= data_i;
        end
    end

    // Transfer sequencer: two SPI frames (A then B) followed by the LDAC pulse.
    // tmr counts down the clocks remaining in the current half-period or pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tmr          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            chan_b       <= 1'b0;
            spi_clk_o    <= 1'b0;
            spi_ssn_o    <= 1'b1;
            spi_mosi_o   <= 1'b0;
            spi_ldac_n_o <= 1'b1;
            busy_o       <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        underrun_o <= ~full;
                        busy_o     <= 1'b1;
                        chan_b     <= 1'b0;
                        shreg      <= word_a;
                        spi_mosi_o <= word_a[15];
                        spi_ssn_o  <= 1'b0;
                        tmr        <= HALF_LAST;
                        state      <= SSN_SETUP;
                    end
                end
                SSN_SETUP: begin
                    // CS_N is low with bit 15 on SDI; first rising edge follows.
                    if (tmr == '0) begin
                        spi_clk_o <= 1'b1;
                        bit_cnt   <= '0;
                        tmr       <= HALF_LAST;
                        state     <= SHIFT;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                SHIFT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TMR_ONE;
                    end else begin
                        tmr <= HALF_LAST;
                        if (spi_clk_o) begin
                            // Falling edge: advance SDI unless the last bit was clocked.
                            spi_clk_o <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state <= SSN_HOLD;
                            end else begin
                                shreg      <= {shreg[14:0], 1'b0};
                                spi_mosi_o <= shreg[14];
                            end
                        end else begin
                            spi_clk_o <= 1'b1;
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
                SSN_HOLD: begin
                    // Keep CS_N low for a half period after the last falling edge.
                    if (tmr == '0) begin
                        spi_ssn_o  <= 1'b1;
                        spi_mosi_o <= 1'b0;
                        tmr        <= HALF_LAST;
                        state      <= GAP;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                GAP: begin
                    // CS_N high for a half period, then frame B or the latch pulse.
                    if (tmr == '0) begin
                        if (!chan_b) begin
                            chan_b     <= 1'b1;
                            shreg      <= word_b;
                            spi_mosi_o <= word_b[15];
                            spi_ssn_o  <= 1'b0;
                            tmr        <= HALF_LAST;
                            state      <= SSN_SETUP;
                        end else begin
                            spi_ldac_n_o <= 1'b0;
                            tmr          <= LDAC_LAST;
                            state        <= LDAC;
                        end
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                LDAC: begin
                    // Both DAC outputs update together while LDAC_N is low.
                    if (tmr == '0) begin
                        spi_ldac_n_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcp4822_ma.sv
// Self-checking bench for mcp4822_ma: random samples against a sample-level reference model.
// Latency: expected pin waveforms derived per cycle from the tick time and frame timing rules.
// Backpressure: exercises full-register stalls, tick/handshake collision and empty-tick underruns.
module tb_mcp4822_ma;

    localparam int CF  = 30000000;
    localparam int SF  = 1000000;
    localparam int SR  = 20000;
    localparam int L   = 2;
    localparam int H   = CF / (2 * SF);
    localparam int TP  = CF / SR;
    localparam int SEQ = 68 * H + L;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] dat   = '0;
    logic        vld   = 1'b0;
    logic        rdy, sclk, ssn, mosi, ldac_n, busy, urun;

    logic [23:0] dat_g = '0;
    logic        vld_g = 1'b0;
    logic        rdy_g, sclk_g, ssn_g, mosi_g, ldac_g, busy_g, urun_g;

    mcp4822_ma #(
        .CLOCK_FREQ(CF), .SCLK_FREQ(SF), .SAMPLE_RATE(SR), .GAIN_2X(0), .LDAC_LEN(L)
    ) dut (
        .clock(clock), .reset(reset), .data_i(dat), .valid_i(vld), .ready_o(rdy),
        .spi_clk_o(sclk), .spi_ssn_o(ssn), .spi_mosi_o(mosi), .spi_ldac_n_o(ldac_n),
        .busy_o(busy), .underrun_o(urun)
    );

    mcp4822_ma #(
        .CLOCK_FREQ(CF), .SCLK_FREQ(SF), .SAMPLE_RATE(SR), .GAIN_2X(1), .LDAC_LEN(L)
    ) dut_g (
        .clock(clock), .reset(reset), .data_i(dat_g), .valid_i(vld_g), .ready_o(rdy_g),
        .spi_clk_o(sclk_g), .spi_ssn_o(ssn_g), .spi_mosi_o(mosi_g), .spi_ldac_n_o(ldac_g),
        .busy_o(busy_g), .underrun_o(urun_g)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // DAC command word from channel, gain setting and sample value.
    function automatic logic [15:0] cmd(input int ch, input int g2x, input logic [11:0] d);
        int w;
        w = int'(d) + 4096;               // SHDN_N = 1
        if (ch == 1) w = w + 32768;       // channel B
        if (g2x == 0) w = w + 8192;       // GA = 1 for 1x
        return 16'(w);
    endfunction

    // ---------------- reference model ----------------
    int          mcnt    = 0;
    int          n_ticks = 0;
    int          t0      = -1000000;
    logic        m_full  = 1'b0;
    logic [23:0] m_hold  = '0;
    logic [11:0] m_a     = 12'h800;
    logic [11:0] m_b     = 12'h800;
    logic        m_ur    = 1'b0;
    logic [15:0] wa      = '0;
    logic [15:0] wb      = '0;
    logic [15:0] exp_q[$];
    bit          m_tick, m_hs;

    always @(posedge clock) cyc <= cyc + 1;

    // Sample-level model: tick every TP cycles, one-slot buffer, repeat on empty.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt   = 0;
            m_full = 1'b0;
            m_a    = 12'h800;
            m_b    = 12'h800;
            m_ur   = 1'b0;
            t0     = -1000000;
            exp_q.delete();
        end else begin
            m_tick = (mcnt == TP - 1);
            m_hs   = vld && !m_full;
            m_ur   = 1'b0;
            if (m_tick) begin
                n_ticks++;
                t0 = cyc + 1;
                if (m_full) begin
                    m_a    = m_hold[11:0];
                    m_b    = m_hold[23:12];
                    m_full = 1'b0;
                end else begin
                    m_ur = 1'b1;
                end
                wa = cmd(0, 0, m_a);
                wb = cmd(1, 0, m_b);
                exp_q.push_back(wa);
                exp_q.push_back(wb);
            end
            if (m_hs) begin
                m_hold = dat;
                m_full = 1'b1;
            end
            mcnt = m_tick ? 0 : mcnt + 1;
        end
    end

    // Expected {busy, ssn, sclk, mosi, ldac_n} for cycle c from the frame timing rules.
    function automatic logic [4:0] exp_pins(input int c);
        int n, f, k;
        logic [15:0] w;
        logic e_busy, e_ssn, e_sclk, e_mosi, e_ldac;
        e_busy = 0; e_ssn = 1; e_sclk = 0; e_mosi = 0; e_ldac = 1;
        n = c - t0;
        if (n >= 0 && n < SEQ) begin
            e_busy = 1;
            if (n >= 68 * H) begin
                e_ldac = 0;
            end else begin
                f = n / (34 * H);
                n = n % (34 * H);
                w = (f == 0) ? wa : wb;
                if (n < 33 * H) begin
                    e_ssn  = 0;
                    k      = n / (2 * H);
                    if (k > 15) k = 15;
                    e_mosi = w[15 - k];
                    e_sclk = (n < 32 * H) && ((n / H) % 2 == 1);
                end
            end
        end
        return {e_busy, e_ssn, e_sclk, e_mosi, e_ldac};
    endfunction

    // ---------------- per-cycle pin checks and frame decoders ----------------
    logic [4:0]  e_pins;
    int          nb = 0, last_rise = 0;
    logic [15:0] sh = '0;
    logic        prev_sclk = 1'b0, prev_ssn = 1'b1;
    logic [15:0] gsh = '0;
    logic [15:0] g_q[$];
    logic        g_prev_sclk = 1'b0, g_prev_ssn = 1'b1, gcap = 1'b1;

    always @(negedge clock) begin
        e_pins = exp_pins(cyc);
        check("ready",    rdy,    !m_full);
        check("underrun", urun,   m_ur);
        check("busy",     busy,   e_pins[4]);
        check("ssn",      ssn,    e_pins[3]);
        check("sclk",     sclk,   e_pins[2]);
        check("mosi",     mosi,   e_pins[1]);
        check("ldac_n",   ldac_n, e_pins[0]);
        if (reset) begin
            nb        = 0;
            prev_sclk = 1'b0;
            prev_ssn  = 1'b1;
        end else begin
            if (sclk && !prev_sclk && !ssn) begin
                if (nb > 0) check("sck_period", cyc - last_rise, 2 * H);
                last_rise = cyc;
                sh = {sh[14:0], mosi};
                nb++;
            end
            if (ssn && !prev_ssn) begin
                check("frame_bits", nb, 16);
                if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
                else check("frame_word", sh, exp_q.pop_front());
                nb = 0;
            end
            prev_sclk = sclk;
            prev_ssn  = ssn;
        end
        if (!reset && gcap) begin
            if (sclk_g && !g_prev_sclk && !ssn_g) gsh = {gsh[14:0], mosi_g};
            if (ssn_g && !g_prev_ssn) begin
                g_q.push_back(gsh);
                if (g_q.size() >= 2) gcap = 1'b0;
            end
            g_prev_sclk = sclk_g;
            g_prev_ssn  = ssn_g;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_tick();
        int n0;
        bit got;
        n0  = n_ticks;
        got = 0;
        for (int i = 0; i < TP + 20; i++) begin
            @(posedge clock);
            #2;
            if (n_ticks != n0) begin
                got = 1;
                break;
            end
        end
        check("tick_timeout", got, 1);
    endtask

    task automatic push(input logic [23:0] d);
        bit ok, acc;
        ok  = 0;
        vld = 1'b1;
        dat = d;
        for (int i = 0; i < 2 * TP; i++) begin
            @(negedge clock);
            acc = rdy;
            @(posedge clock);
            #2;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        vld = 1'b0;
        check("push_timeout", ok, 1);
    endtask

    int rel;
    int k0;
    bit found;

    initial begin
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        rel   = cyc;
        @(negedge clock);
        check("rst_ready", rdy, 1);
        check("rst_ssn", ssn, 1);
        check("rst_ldac", ldac_n, 1);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);

        // Gain-2x instance gets {FFF, 000} before its first tick.
        vld_g = 1'b1;
        dat_g = {12'hFFF, 12'h000};
        @(posedge clock);
        #2;
        vld_g = 1'b0;
        check("g_accept", rdy_g, 0);

        // Empty register at first tick: midscale repeat and underrun.
        wait_tick();
        check("first_tick_time", t0 - rel, TP);
        wait_cycles(SEQ + 5);

        // Single sample before a tick.
        push({12'h123, 12'hABC});
        check("full_after_push", rdy, 0);
        wait_tick();
        wait_cycles(SEQ + 5);

        // Back-to-back: second sample waits for the tick to free the register.
        push({12'h456, 12'h789});
        k0 = n_ticks;
        push({12'hFED, 12'h00F});
        check("b2b_ticks", n_ticks - k0, 1);
        check("b2b_accept_cycle", cyc - t0, 1);
        wait_tick();
        wait_cycles(SEQ + 5);

        // Handshake exactly on the tick cycle with the register empty.
        found = 0;
        for (int i = 0; i < 2 * TP; i++) begin
            if (mcnt == TP - 1) begin
                found = 1;
                break;
            end
            @(posedge clock);
            #2;
        end
        check("tick_align", found, 1);
        vld = 1'b1;
        dat = {12'h5A5, 12'hA5A};
        @(posedge clock);
        #2;
        vld = 1'b0;
        check("tick_hs_held", rdy, 0);
        wait_tick();
        wait_cycles(SEQ + 5);

        // Random samples, sometimes skipped to force underruns.
        for (int i = 0; i < 6; i++) begin
            wait_cycles($urandom_range(1, 300));
            if ($urandom_range(0, 3) != 0) push(24'($urandom));
            wait_tick();
            wait_cycles(SEQ + 5);
        end

        // Reset in the middle of frame A (8th SCK high phase).
        push({12'h321, 12'h654});
        wait_tick();
        found = 0;
        for (int i = 0; i < 40 * H; i++) begin
            if (cyc >= t0 + 15 * H) begin
                found = 1;
                break;
            end
            @(posedge clock);
            #2;
        end
        check("mid_align", found, 1);
        check("pre_rst_sclk", sclk, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ssn", ssn, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_ldac", ldac_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", rdy, 1);
        wait_cycles(2);
        reset = 1'b0;
        rel   = cyc;
        wait_tick();
        check("post_rst_tick_time", t0 - rel, TP);
        wait_cycles(SEQ + 5);

        check("frames_pending", exp_q.size(), 0);
        check("g_frame_cnt", g_q.size(), 2);
        if (g_q.size() >= 2) begin
            check("g_frame_a", g_q[0], 16'h1000);
            check("g_frame_b", g_q[1], 16'h9FFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
